// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU share arbiter: FSM state encoding,
// opcode values and the operand width.
package alu_arb_pkg;

   localparam int W = 4;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_share_arbiter_addsub4_sm.sv
// Combinational 4-bit add / sign-magnitude subtract. Add returns {carry, sum};
// subtract returns {A<B, |A-B|}, so equal operands give all zeros.
module addsub4_sm
   import alu_arb_pkg::*;
(
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_op,
   output logic [W:0]   o_res
);

   always_comb begin
      o_res = '0;
      if (i_op == OP_ADD) begin
         o_res = {1'b0, i_a} + {1'b0, i_b};
      end else if (i_a < i_b) begin
         o_res = {1'b1, i_b - i_a};
      end else begin
         o_res = {1'b0, i_a - i_b};
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one add/subtract unit among N_REQ requesters.
// Optional build macro ALU_ARB_STATS_EN adds a saturating completed-op counter (op_count).
//
// state | meaning
// IDLE  | waiting for any req_valid; grants and latches the round-robin winner
// EXEC  | latched operands pass through the datapath into the result register
// RESP  | result held on rsp_* until rsp_ready
module alu_share_arbiter #(
   parameter int N_REQ = 4,
   parameter int W     = alu_arb_pkg::W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req_valid,
   output logic [N_REQ-1:0]           req_ready,
   input  logic [N_REQ*W-1:0]         req_a,
   input  logic [N_REQ*W-1:0]         req_b,
   input  logic [N_REQ-1:0]           req_op,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [$clog2(N_REQ)-1:0]   rsp_id,
   output logic [W:0]                 rsp_data,
   output logic                       busy
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [7:0]                 op_count
`endif
);

   import alu_arb_pkg::*;

   localparam int IDW = $clog2(N_REQ);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDW-1:0]   r_last_grant;
   logic [IDW-1:0]   r_id;
   logic [IDW-1:0]   r_rsp_id;
   logic [IDW-1:0]   w_winner;
   logic [W-1:0]     r_a;
   logic [W-1:0]     r_b;
   logic             r_op;
   logic [W-1:0]     w_sel_a;
   logic [W-1:0]     w_sel_b;
   logic             w_sel_op;
   logic [W:0]       w_res;
   logic [W:0]       r_rsp_data;
   logic             r_rsp_valid;
   logic             r_busy;
   logic             w_accept;
   logic [N_REQ-1:0] w_grant;

   // First valid requester searching upward from last+1, wrapping around.
   function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [IDW-1:0]   last);
      logic found;
      int   idx;
      rr_pick = '0;
      found   = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last) + k) % N_REQ;
         if (!found && valid[idx]) begin
            rr_pick = IDW'(idx);
            found   = 1'b1;
         end
      end
   endfunction

   always_comb begin
      w_winner = rr_pick(req_valid, r_last_grant);
      w_sel_a  = '0;
      w_sel_b  = '0;
      w_sel_op = OP_ADD;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_winner == IDW'(i)) begin
            w_sel_a  = req_a[i*W +: W];
            w_sel_b  = req_b[i*W +: W];
            w_sel_op = req_op[i];
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = '0;
      case (r_state)
         IDLE: begin
            if (|req_valid) begin
               w_grant[w_winner] = 1'b1;
               w_state_nxt       = EXEC;
            end
         end
         EXEC:    w_state_nxt = RESP;
         RESP: begin
            if (rsp_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_accept  = (r_state == IDLE) && (|req_valid);
   // Gated by rst so no strobe escapes while the state register is being cleared.
   assign req_ready = rst ? w_grant : '0;

   addsub4_sm u_addsub (
      .i_a   (r_a),
      .i_b   (r_b),
      .i_op  (r_op),
      .o_res (w_res)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state      <= IDLE;
         r_last_grant <= IDW'(N_REQ - 1);
         r_id         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_op         <= OP_ADD;
         r_rsp_id     <= '0;
         r_rsp_data   <= '0;
         r_rsp_valid  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rsp_valid <= (w_state_nxt == RESP);
         r_busy      <= (w_state_nxt != IDLE);
         if (w_accept) begin
            r_a          <= w_sel_a;
            r_b          <= w_sel_b;
            r_op         <= w_sel_op;
            r_id         <= w_winner;
            r_last_grant <= w_winner;
         end
         if (r_state == EXEC) begin
            r_rsp_data <= w_res;
            r_rsp_id   <= r_id;
         end
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;
   assign busy      = r_busy;

`ifdef ALU_ARB_STATS_EN
   logic [7:0] r_op_count;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_op_count <= '0;
      end else if ((r_state == RESP) && rsp_ready && (r_op_count != 8'hFF)) begin
         r_op_count <= r_op_count + 8'd1;
      end
   end

   assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: expected {id, data} pushed at each
// accept, popped and compared when the response appears.
module tb_alu_share_arbiter;
   import alu_arb_pkg::*;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*4-1:0] req_a;
   logic [N*4-1:0] req_b;
   logic [N-1:0]   req_op;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [1:0]     rsp_id;
   logic [4:0]     rsp_data;
   logic           busy;
`ifdef ALU_ARB_STATS_EN
   logic [7:0]     op_count;
`endif

   typedef struct packed {
      logic [1:0] id;
      logic [4:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_last;
   int   a_tab[N];
   int   b_tab[N];
   int   op_tab[N];

   alu_share_arbiter #(.N_REQ(N), .W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy)
`ifdef ALU_ARB_STATS_EN
      ,
      .op_count  (op_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] model_res(input int a, input int b, input int op);
      if (op == 0) return 5'(a + b);
      if (a < b) return {1'b1, 4'(b - a)};
      return {1'b0, 4'(a - b)};
   endfunction

   function automatic int model_pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] onehot(input int idx);
      logic [N-1:0] v;
      v = '0;
      if (idx >= 0) v[idx] = 1'b1;
      return v;
   endfunction

   task automatic set_req(input int i, input int a, input int b, input int op);
      req_a[i*4 +: 4] = 4'(a);
      req_b[i*4 +: 4] = 4'(b);
      req_op[i]       = (op != 0);
      a_tab[i] = a; b_tab[i] = b; op_tab[i] = op;
   endtask

   task automatic test_reset();
      int   w, lat;
      exp_t e;
      rst = 1'b0; rsp_ready = 1'b0; req_valid = '1;
      for (int i = 0; i < N; i++) set_req(i, i + 1, i, 0);
      repeat (3) @(negedge clk);
      n_checks++; if (req_ready !== 4'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
      n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
      n_checks++; if (rsp_data !== 5'd0) begin n_fail++; $display("FAIL reset_rsp_data: got %b want 00000", rsp_data); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      rst = 1'b1; m_last = N - 1; #1;
      w = model_pick(req_valid, m_last);
      n_checks++; if (req_ready !== onehot(w)) begin n_fail++; $display("FAIL first_grant: got %b want %b", req_ready, onehot(w)); end
      sb_q.push_back(exp_t'{id: 2'(w), data: model_res(a_tab[w], b_tab[w], op_tab[w])});
      m_last = w;
      @(posedge clk); @(negedge clk);
      req_valid = '0;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL exec_busy: got %b want 1", busy); end
      lat = 1;
      while (!rsp_valid && lat < 8) begin @(negedge clk); lat++; end
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL first_latency: got %0d want 2", lat); end
      e = sb_q.pop_front();
      n_checks++; if (rsp_id !== e.id) begin n_fail++; $display("FAIL first_rsp_id: got %0d want %0d", rsp_id, e.id); end
      n_checks++; if (rsp_data !== e.data) begin n_fail++; $display("FAIL first_rsp_data: got %b want %b", rsp_data, e.data); end
      rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
      n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL first_release: got valid=%b busy=%b want 0 0", rsp_valid, busy); end
   endtask

   task automatic test_arith();
      int   t_id[5]  = '{2, 1, 0, 1, 3};
      int   t_a[5]   = '{3, 15, 7, 9, 8};
      int   t_b[5]   = '{5, 15, 7, 4, 9};
      int   t_op[5]  = '{1, 0, 1, 1, 0};
      logic [4:0] t_exp[5] = '{5'b1_0010, 5'b1_1110, 5'b0_0000, 5'b0_0101, 5'b1_0001};
      int   w, lat, id;
      exp_t e;
      for (int v = 0; v < 5; v++) begin
         id = t_id[v];
         req_valid = '0; set_req(id, t_a[v], t_b[v], t_op[v]); req_valid[id] = 1'b1; #1;
         w = model_pick(req_valid, m_last);
         n_checks++; if (req_ready !== onehot(w)) begin n_fail++; $display("FAIL arith_grant[%0d]: got %b want %b", v, req_ready, onehot(w)); end
         sb_q.push_back(exp_t'{id: 2'(id), data: t_exp[v]});
         m_last = w;
         @(posedge clk); @(negedge clk);
         req_valid = '0; set_req(id, t_a[v] ^ 15, t_b[v] ^ 3, 1 - t_op[v]);
         lat = 1;
         while (!rsp_valid && lat < 8) begin @(negedge clk); lat++; end
         n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL arith_latency[%0d]: got %0d want 2", v, lat); end
         e = sb_q.pop_front();
         n_checks++; if (rsp_id !== e.id) begin n_fail++; $display("FAIL arith_id[%0d]: got %0d want %0d", v, rsp_id, e.id); end
         n_checks++; if (rsp_data !== e.data) begin n_fail++; $display("FAIL arith_data[%0d]: got %b want %b", v, rsp_data, e.data); end
         rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
      end
   endtask

   task automatic test_fairness();
      int   w, cyc, last_cyc, accepts;
      int   order[$];
      exp_t e;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 3*i + 1, 15 - 2*i, i % 2);
      req_valid = '1;
      cyc = 0; last_cyc = 0; accepts = 0;
      while ((accepts < 5 || sb_q.size() > 0) && cyc < 40) begin
         #1;
         if (rsp_valid) begin
            e = sb_q.pop_front();
            n_checks++; if (rsp_id !== e.id || rsp_data !== e.data) begin n_fail++; $display("FAIL rr_rsp: got id=%0d data=%b want id=%0d data=%b", rsp_id, rsp_data, e.id, e.data); end
         end
         if (req_ready !== '0 && accepts < 5) begin
            w = model_pick(req_valid, m_last);
            n_checks++; if (req_ready !== onehot(w)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", accepts, req_ready, onehot(w)); end
            if (accepts > 0) begin
               n_checks++; if (cyc - last_cyc !== 3) begin n_fail++; $display("FAIL rr_interval[%0d]: got %0d want 3", accepts, cyc - last_cyc); end
            end
            sb_q.push_back(exp_t'{id: 2'(w), data: model_res(a_tab[w], b_tab[w], op_tab[w])});
            order.push_back(w);
            m_last = w; last_cyc = cyc; accepts++;
         end
         @(posedge clk); #1;
         if (accepts == 5) req_valid = '0;
         @(negedge clk); cyc++;
      end
      n_checks++; if (accepts !== 5 || sb_q.size() !== 0) begin n_fail++; $display("FAIL rr_timeout: got accepts=%0d pending=%0d want 5 0", accepts, sb_q.size()); end
      n_checks++; if (order.size() != 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3 || order[4] != 0)
         begin n_fail++; $display("FAIL rr_order: got %p want 0 1 2 3 0", order); end
      rsp_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      int   w, lat;
      exp_t e;
      rsp_ready = 1'b0;
      req_valid = '0; set_req(2, 10, 12, 1); req_valid[2] = 1'b1; #1;
      w = model_pick(req_valid, m_last);
      n_checks++; if (req_ready !== onehot(w)) begin n_fail++; $display("FAIL bp_grant: got %b want %b", req_ready, onehot(w)); end
      sb_q.push_back(exp_t'{id: 2'(w), data: 5'b1_0010});
      m_last = w;
      @(posedge clk); @(negedge clk);
      req_valid = '0; set_req(1, 4, 6, 0); req_valid[1] = 1'b1;
      @(negedge clk);
      e = sb_q.pop_front();
      for (int k = 0; k < 5; k++) begin
         #1;
         n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_id !== e.id || req_ready !== '0)
            begin n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%b id=%0d rdy=%b want 1 %b %0d 0000", k, rsp_valid, rsp_data, rsp_id, req_ready, e.data, e.id); end
         @(negedge clk);
      end
      rsp_ready = 1'b1; #1;
      n_checks++; if (req_ready !== '0) begin n_fail++; $display("FAIL bp_no_early_accept: got %b want 0000", req_ready); end
      @(negedge clk); rsp_ready = 1'b0; #1;
      w = model_pick(req_valid, m_last);
      n_checks++; if (req_ready !== onehot(w)) begin n_fail++; $display("FAIL bp_next_grant: got %b want %b", req_ready, onehot(w)); end
      sb_q.push_back(exp_t'{id: 2'(w), data: model_res(a_tab[w], b_tab[w], op_tab[w])});
      m_last = w;
      @(posedge clk); @(negedge clk);
      req_valid = '0;
      lat = 1;
      while (!rsp_valid && lat < 8) begin @(negedge clk); lat++; end
      e = sb_q.pop_front();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_data !== e.data)
         begin n_fail++; $display("FAIL bp_second_rsp: got v=%b id=%0d d=%b want 1 %0d %b", rsp_valid, rsp_id, rsp_data, e.id, e.data); end
      rsp_ready = 1'b1; @(negedge clk); rsp_ready = 1'b0;
   endtask

   task automatic test_reset_exec();
      int w;
      int seen;
      req_valid = '0; set_req(0, 5, 2, 1); req_valid[0] = 1'b1; #1;
      w = model_pick(req_valid, m_last);
      n_checks++; if (req_ready !== onehot(w)) begin n_fail++; $display("FAIL rx_grant: got %b want %b", req_ready, onehot(w)); end
      @(posedge clk); @(negedge clk);
      rst = 1'b0; req_valid = '0;
      @(negedge clk);
      rst = 1'b1; m_last = N - 1;
      seen = 0;
      for (int k = 0; k < 4; k++) begin
         if (rsp_valid !== 1'b0 || busy !== 1'b0) seen++;
         @(negedge clk);
      end
      n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rx_no_rsp: got %0d active cycles want 0", seen); end
      n_checks++; if (rsp_data !== 5'd0) begin n_fail++; $display("FAIL rx_data_cleared: got %b want 00000", rsp_data); end
      req_valid = 4'b1010; #1;
      w = model_pick(req_valid, m_last);
      n_checks++; if (req_ready !== onehot(w)) begin n_fail++; $display("FAIL rx_priority: got %b want %b", req_ready, onehot(w)); end
      req_valid = '0;
      @(negedge clk);
   endtask

`ifdef ALU_ARB_STATS_EN
   task automatic test_stats();
      int hs, cyc;
      @(negedge clk); rst = 1'b0; @(negedge clk); rst = 1'b1;
      n_checks++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL stats_clear: got %0d want 0", op_count); end
      rsp_ready = 1'b1; req_valid = 4'b0001; set_req(0, 1, 1, 0);
      hs = 0; cyc = 0;
      while (hs < 300 && cyc < 1200) begin
         @(negedge clk); cyc++;
         if (rsp_valid) begin
            hs++;
            if (hs == 100) begin
               n_checks++; if (op_count !== 8'd99) begin n_fail++; $display("FAIL stats_mid: got %0d want 99", op_count); end
            end
         end
      end
      req_valid = '0;
      @(negedge clk);
      n_checks++; if (hs !== 300) begin n_fail++; $display("FAIL stats_timeout: got %0d ops want 300", hs); end
      n_checks++; if (op_count !== 8'd255) begin n_fail++; $display("FAIL stats_saturate: got %0d want 255", op_count); end
      rsp_ready = 1'b0; rst = 1'b0; @(negedge clk); rst = 1'b1; m_last = N - 1;
      n_checks++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL stats_reset: got %0d want 0", op_count); end
   endtask
`endif

   initial begin
      req_a = '0; req_b = '0; req_op = '0; req_valid = '0; rsp_ready = 1'b0; rst = 1'b0;
      @(negedge clk);
      test_reset();
      test_arith();
      test_fairness();
      test_backpressure();
      test_reset_exec();
`ifdef ALU_ARB_STATS_EN
      test_stats();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter and sequencer sharing one 4-bit add/subtract datapath among `N_REQ` requesters. Each requester presents operands and an opcode with a valid/ready handshake. The block grants one requester, latches its operands, and computes the result in a registered execute cycle. It then holds the tagged result on a response port until it is consumed. It sits between the lab's requester FSMs (display/test sequencers) and the single shared arithmetic unit.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `W`, default 4: operand width. Fixed at 4 in this revision.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_ready`  out  N_REQ  one-hot accept strobe.
- `req_a`  in  N_REQ*W  operand A; requester i at [i*W +: W].
- `req_b`  in  N_REQ*W  operand B, same packing.
- `req_op`  in  N_REQ  0 = add, 1 = subtract (A−B).
- `rsp_valid`  out  1  result valid.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_id`  out  $clog2(N_REQ)  index of the requester that owns the result.
- `rsp_data`  out  W+1  result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `req_valid` is high, the winner is the first set bit searching upward (with wrap) from `last_grant+1`.
  - `req_ready[winner]`=1 combinationally in that cycle.
  - On the clock edge: latch a, b, op and id; `last_grant`←winner; go to EXEC.
  - If no `req_valid` is high, stay in IDLE and keep all `req_ready` low.
- **EXEC**
  - Drive the latched operands through the datapath and register the result into `rsp_data`.
  - Go to RESP.
  - `req_ready` is all-zero.
- **RESP**
  - `rsp_valid`=1. `rsp_data` and `rsp_id` are stable.
  - When `rsp_ready`=1, go to IDLE on the next edge.
  - With no `rsp_ready`, hold indefinitely.
- **Arithmetic**
  - Add: `rsp_data` = A+B as an unsigned 5-bit value, with bit 4 = carry.
  - Subtract: sign-magnitude. `rsp_data[4]`=1 when A<B; `rsp_data[3:0]`=|A−B|.
  - Equal operands give 5'b0_0000.
- `req_valid` may drop before acceptance without penalty. Operands are sampled only on the accept edge; later changes are ignored.
- The arbiter never accepts a new request while in EXEC or RESP. It has no queue.

## Timing
- Reset (`rst`=0 at an edge):
  - FSM→IDLE.
  - `last_grant`←N_REQ−1, so requester 0 has first priority.
  - `req_ready`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `busy`=0.
- Reset mid-transaction discards the in-flight operation. No response is issued.
- Latency: accept at edge T gives `rsp_valid` high from T+2.
- Minimum issue interval is 3 cycles when `rsp_ready` is held high.
- Fairness: with all requesters continuously valid, the grant order is 0,1,…,N_REQ−1,0,…
- A requester that is granted, drops, and re-asserts waits its turn.
- `rsp_ready` asserted outside RESP is ignored.
- `req_ready` is combinational from `req_valid` and state. All other outputs are registered.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - Adds output `op_count` (8 bits).
  - Increments on each RESP→IDLE handshake and saturates at 255.
  - Cleared by `rst`.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `alu_arb_pkg`:
  - state enum (IDLE/EXEC/RESP).
  - opcode constants `OP_ADD`=1'b0 and `OP_SUB`=1'b1.
  - `W`.
- Sub-module `addsub4_sm`: combinational 4-bit add / sign-magnitude subtract. It is instantiated once, between the operand latches and the result register.
- The round-robin pick is a function inside the arbiter.

## Test plan
- Reset with all `req_valid`=1 → all outputs 0 during reset. The first grant goes to req 0, and `rsp_id`=0 appears two cycles after the accept.
- Single req 2: A=3, B=5, op=sub → `rsp_data`=5'b1_0010, `rsp_id`=2.
- A=15, B=15, op=add → `rsp_data`=5'b1_1110. A=7, B=7, op=sub → 5'b0_0000.
- All four requesters held valid, `rsp_ready`=1 → grant sequence 0,1,2,3,0, one accept every 3 cycles.
- `rsp_ready` low for 5 cycles in RESP, with req 1 valid → `rsp_valid`/`rsp_data` stable and no `req_ready`. The accept occurs the cycle after the handshake.
- `rst` pulsed in EXEC → no `rsp_valid`. With `ALU_ARB_STATS_EN`: 300 completed ops → `op_count`=255, and it is cleared by that reset.
